// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: fixed-latency mult/div with pending-result commit and mthi/mtlo writes.
// Optional flush input `cancel` is enabled by defining MDU_CANCEL_EN.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        start,
  input  logic [2:0]  MD_OP,
  input  logic        hilo_we,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        wr_q, wr_d;
  logic        kill;

`ifdef MDU_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  logic [63:0] prod_s, prod_u;
  logic        sgn;
  logic [31:0] dvd, dvs, q_mag, r_mag, quot, rem;

  // One unsigned divider serves both div and divu; signed div works on magnitudes.
  // 0x80000000 / -1 falls out naturally: magnitude 2^31, no sign flip.
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'b0, A} * {32'b0, B};
    sgn    = (MD_OP[1:0] == 2'd2);
    dvd    = (sgn && A[31]) ? -A : A;
    dvs    = (sgn && B[31]) ? -B : B;
    if (dvs == 32'd0) dvs = 32'd1;
    q_mag  = dvd / dvs;
    r_mag  = dvd % dvs;
    quot   = (sgn && (A[31] ^ B[31])) ? -q_mag : q_mag;
    rem    = (sgn && A[31]) ? -r_mag : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (kill) begin
      state_d = IDLE;
      cnt_d   = '0;
      wr_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !MD_OP[2]) begin
            state_d = BUSY;
            if (MD_OP[1]) begin
              cnt_d = DIV_LD;
              phi_d = rem;
              plo_d = quot;
              wr_d  = (B != 32'd0);
            end else begin
              cnt_d          = MULT_LD;
              {phi_d, plo_d} = MD_OP[0] ? prod_u : prod_s;
              wr_d           = 1'b1;
            end
          end else if (hilo_we) begin
            if (MD_OP == 3'd4) hi_d = A;
            else if (MD_OP == 3'd5) lo_d = A;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            wr_d    = 1'b0;
            if (wr_q) begin
              hi_d = phi_q;
              lo_d = plo_q;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (cancel path exercised when MDU_CANCEL_EN is defined).
module tb_mult_div_unit;
  logic        clk, reset, start, hilo_we, busy;
  logic [2:0]  MD_OP;
  logic [31:0] A, B, HI, LO;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  int n_chk = 0;
  int n_err = 0;
  int n;

  mult_div_unit dut (
    .clk(clk), .reset(reset),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .start(start), .MD_OP(MD_OP), .hilo_we(hilo_we),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; MD_OP = op; A = a; B = b;
    tick();
    start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
  endtask

  task automatic hilo_write(input logic [2:0] op, input logic [31:0] a);
    hilo_we = 1'b1; MD_OP = op; A = a;
    tick();
    hilo_we = 1'b0; MD_OP = 3'd0;
  endtask

  // Counts busy cycles from the current sample point; bounded.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hilo_we = 1'b0; MD_OP = 3'd0; A = '0; B = '0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);

    // mult -1 * 2
    launch(3'd0, 32'hFFFF_FFFF, 32'd2);
    chk("mult_hi_during", HI, 32'd0);
    chk("mult_lo_during", LO, 32'd0);
    wait_idle(n);
    chk("mult_cycles", n, 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFE);

    // multu same operands
    launch(3'd1, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi_during", HI, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("multu_cycles", n, 32'd5);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    // div -7 / 2
    launch(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_cycles", n, 32'd10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    // div 7 / -2 -> q=-3 r=1
    launch(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    chk("divnb_lo", LO, 32'hFFFF_FFFD);
    chk("divnb_hi", HI, 32'd1);

    // overflow case
    launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'd0);

    // divu 100 / 7
    launch(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);

    // mthi / mtlo, then divu by zero leaves them
    hilo_write(3'd4, 32'h11);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_hi", HI, 32'h11);
    hilo_write(3'd5, 32'h22);
    chk("mtlo_lo", LO, 32'h22);
    chk("mtlo_hi", HI, 32'h11);
    hilo_write(3'd0, 32'h99);
    chk("we_op0_hi", HI, 32'h11);
    chk("we_op0_lo", LO, 32'h22);
    launch(3'd6, 32'd1, 32'd1);
    chk("rsvd_busy", {31'b0, busy}, 32'd0);
    launch(3'd3, 32'd7, 32'd0);
    wait_idle(n);
    chk("div0_cycles", n, 32'd10);
    chk("div0_hi", HI, 32'h11);
    chk("div0_lo", LO, 32'h22);

    // mult 3*4 with stray start and mthi while busy
    launch(3'd0, 32'd3, 32'd4);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) n++;
      start   = (i == 1);
      hilo_we = (i == 2);
      MD_OP   = (i == 1) ? 3'd2 : (i == 2) ? 3'd4 : 3'd0;
      A       = (i == 1) ? 32'd100 : (i == 2) ? 32'h55 : 32'd0;
      B       = 32'd7;
      tick();
    end
    start = 1'b0; hilo_we = 1'b0; MD_OP = 3'd0;
    chk("stray_cycles", n, 32'd5);
    chk("stray_hi", HI, 32'd0);
    chk("stray_lo", LO, 32'd12);

    // reset at busy cycle 3 of divu 100/7
    launch(3'd3, 32'd100, 32'd7);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_hi", HI, 32'd0);
    chk("rstmid_lo", LO, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("rstmid_lo_late", LO, 32'd0);

`ifdef MDU_CANCEL_EN
    hilo_write(3'd4, 32'hAA);
    hilo_write(3'd5, 32'hBB);
    launch(3'd3, 32'd100, 32'd7);
    tick(); tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", {31'b0, busy}, 32'd0);
    chk("cancel_hi", HI, 32'hAA);
    chk("cancel_lo", LO, 32'hBB);
    for (int i = 0; i < 12; i++) tick();
    chk("cancel_lo_late", LO, 32'hBB);
    cancel = 1'b1;
    hilo_write(3'd4, 32'hCC);
    cancel = 1'b0;
    chk("cancel_we", HI, 32'hAA);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
